// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_pkg
//  Description : Shared types and constants for the SCCB init sequencer:
//                FSM state encoding, end-of-table marker and the
//                register address that encodes a millisecond delay entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        ISSUE   = 4'd3,
        WAIT    = 4'd4,
        DELAY   = 4'd5,
        READY   = 4'd6,
        H_ISSUE = 4'd7,
        H_WAIT  = 4'd8
    } sccb_state_t;

    // Table entry that terminates the init sequence.
    localparam logic [15:0] END_WORD  = 16'hFFFF;
    // Register address marking a delay entry; reg_data is the delay in ms.
    localparam logic [7:0]  DELAY_REG = 8'hFE;

endpackage
`default_nettype wire

// File: rtl/sccb_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_sequencer_if
//  Description : Host request channel and SCCB write-engine command channel
//                of the sequencer.
//                master : sequencer side (drives host_ready, wr_valid,
//                         wr_reg, wr_data)
//                slave  : environment side (drives host_valid, host_reg,
//                         host_data, wr_ready, wr_done, wr_ack_ok)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sccb_sequencer_if;

    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_reg;
    logic [7:0] host_data;

    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       wr_ack_ok;

    modport master (
        input  host_valid, host_reg, host_data, wr_ready, wr_done, wr_ack_ok,
        output host_ready, wr_valid, wr_reg, wr_data
    );

    modport slave (
        output host_valid, host_reg, host_data, wr_ready, wr_done, wr_ack_ok,
        input  host_ready, wr_valid, wr_reg, wr_data
    );

endinterface
`default_nettype wire

// File: rtl/sccb_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_delay_timer
//  Description : Millisecond delay timer. A load pulse captures a ms count;
//                a prescaler divides clk by CLKS_PER_MS and an 8-bit
//                down-counter counts milliseconds, so the pair spans up to
//                255*CLKS_PER_MS cycles. o_expired is high for one cycle,
//                exactly ms*CLKS_PER_MS cycles after the load edge
//                (1 cycle when the count is zero).
//  Ports       : clk, reset (async active-low), i_load, i_ms_count[7:0],
//                o_expired
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_delay_timer #(
    parameter int CLKS_PER_MS = 50000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       i_load,
    input  wire logic [7:0] i_ms_count,
    output logic            o_expired
);

    localparam int                 c_PRE_W   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLKS_PER_MS - 1);

    logic               r_active;
    logic [7:0]         r_ms;
    logic [c_PRE_W-1:0] r_pre;
    logic               w_expired;

    // Last cycle of the final millisecond, or immediately for a zero count.
    assign w_expired = r_active && ((r_ms == 8'd0) || ((r_ms == 8'd1) && (r_pre == '0)));
    assign o_expired = w_expired;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
            r_ms     <= '0;
            r_pre    <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_ms     <= i_ms_count;
            r_pre    <= c_PRE_MAX;
        end else if (r_active) begin
            if (w_expired) begin
                r_active <= 1'b0;
            end else if (r_pre == '0) begin
                r_pre <= c_PRE_MAX;
                r_ms  <= r_ms - 8'd1;
            end else begin
                r_pre <= r_pre - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sccb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_sequencer
//  Description : Walks a {reg_addr, reg_data} config ROM and issues each
//                entry to an SCCB write engine, retrying NACKed writes up to
//                MAX_RETRY attempts. After the table it serves runtime host
//                register writes with the same retry rules.
//                Optional feature macro: SCCB_SEQ_DELAY_EN
//                  defined   : 8'hFE entries wait reg_data milliseconds
//                  undefined : 8'hFE entries are skipped in one cycle
//  Ports       : clk, reset (async active-low), start,
//                rom_addr[7:0] / rom_data[15:0] (1-cycle sync ROM),
//                bus (sccb_sequencer_if.master: host + write channels),
//                busy, init_done (sticky), err (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_sequencer
    import sccb_pkg::*;
#(
    parameter int ROM_DEPTH   = 72,
    parameter int CLKS_PER_MS = 50000,
    parameter int MAX_RETRY   = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    output logic [7:0]       rom_addr,
    input  wire logic [15:0] rom_data,
    sccb_sequencer_if.master bus,
    output logic             busy,
    output logic             init_done,
    output logic             err
);

    localparam int                   c_RETRY_W    = $clog2(MAX_RETRY + 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_LAST = c_RETRY_W'(MAX_RETRY - 1);
    localparam logic [7:0]           c_ROM_END    = 8'(ROM_DEPTH);

    sccb_state_t          r_state;
    logic [7:0]           r_rom_addr;
    logic [c_RETRY_W-1:0] r_retry;
    logic                 r_init_done;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_host_ready;
    logic                 r_wr_valid;
    logic [7:0]           r_wr_reg;
    logic [7:0]           r_wr_data;

    logic                 w_at_end;
    logic [7:0]           w_addr_next;
    logic                 w_decode_end;
    logic                 w_last_try;

    assign w_at_end     = (r_rom_addr == c_ROM_END);
    // Address saturates at ROM_DEPTH so a table without END_WORD still stops.
    assign w_addr_next  = w_at_end ? r_rom_addr : (r_rom_addr + 8'd1);
    assign w_decode_end = (rom_data == END_WORD) || w_at_end;
    // Current NACK would be the MAX_RETRY-th failed attempt.
    assign w_last_try   = (r_retry == c_RETRY_LAST);

`ifdef SCCB_SEQ_DELAY_EN
    logic w_tmr_load;
    logic w_tmr_expired;

    assign w_tmr_load = (r_state == DECODE) && !w_decode_end && (rom_data[15:8] == DELAY_REG);

    sccb_delay_timer #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_delay_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_ms_count (rom_data[7:0]),
        .o_expired  (w_tmr_expired)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rom_addr   <= '0;
            r_retry      <= '0;
            r_init_done  <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_host_ready <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_reg     <= '0;
            r_wr_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rom_addr  <= '0;
                        r_retry     <= '0;
                        r_init_done <= 1'b0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= FETCH;
                    end
                end

                // rom_addr is already stable; ROM data is valid next cycle.
                FETCH: r_state <= DECODE;

                DECODE: begin
                    if (w_decode_end) begin
                        r_init_done  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_host_ready <= 1'b1;
                        r_state      <= READY;
                    end else if (rom_data[15:8] == DELAY_REG) begin
`ifdef SCCB_SEQ_DELAY_EN
                        r_state    <= DELAY;
`else
                        r_rom_addr <= w_addr_next;
                        r_state    <= FETCH;
`endif
                    end else begin
                        r_wr_reg   <= rom_data[15:8];
                        r_wr_data  <= rom_data[7:0];
                        r_wr_valid <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end

                ISSUE, H_ISSUE: begin
                    if (r_wr_valid && bus.wr_ready) begin
                        r_wr_valid <= 1'b0;
                        r_state    <= (r_state == ISSUE) ? WAIT : H_WAIT;
                    end
                end

                // wr_done is only honoured here, so a stray pulse elsewhere
                // (e.g. after a reset mid-transaction) has no effect.
                WAIT, H_WAIT: begin
                    if (bus.wr_done) begin
                        if (bus.wr_ack_ok || w_last_try) begin
                            r_retry <= '0;
                            if (!bus.wr_ack_ok) begin
                                r_err <= 1'b1;
                            end
                            if (r_state == WAIT) begin
                                r_rom_addr <= w_addr_next;
                                r_state    <= FETCH;
                            end else begin
                                r_busy       <= 1'b0;
                                r_host_ready <= 1'b1;
                                r_state      <= READY;
                            end
                        end else begin
                            // Reissue the same command; wr_reg/wr_data held.
                            r_retry    <= r_retry + 1'b1;
                            r_wr_valid <= 1'b1;
                            r_state    <= (r_state == WAIT) ? ISSUE : H_ISSUE;
                        end
                    end
                end

`ifdef SCCB_SEQ_DELAY_EN
                DELAY: begin
                    if (w_tmr_expired) begin
                        r_rom_addr <= w_addr_next;
                        r_state    <= FETCH;
                    end
                end
`endif

                READY: begin
                    // Restart wins over a simultaneous host request.
                    if (start) begin
                        r_rom_addr   <= '0;
                        r_retry      <= '0;
                        r_init_done  <= 1'b0;
                        r_err        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_host_ready <= 1'b0;
                        r_state      <= FETCH;
                    end else if (bus.host_valid && r_host_ready) begin
                        r_wr_reg     <= bus.host_reg;
                        r_wr_data    <= bus.host_data;
                        r_wr_valid   <= 1'b1;
                        r_retry      <= '0;
                        r_busy       <= 1'b1;
                        r_host_ready <= 1'b0;
                        r_state      <= H_ISSUE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_addr       = r_rom_addr;
    assign busy           = r_busy;
    assign init_done      = r_init_done;
    assign err            = r_err;
    assign bus.host_ready = r_host_ready;
    assign bus.wr_valid   = r_wr_valid;
    assign bus.wr_reg     = r_wr_reg;
    assign bus.wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_sccb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_sequencer
//  Description : Self-checking bench for sccb_sequencer. A reference model
//                walks the ROM table and the planned ACK pattern and queues
//                the expected write commands; an engine/monitor process
//                answers the write channel and pops/compares each command.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_sequencer;

    localparam int ROM_DEPTH   = 8;
    localparam int CLKS_PER_MS = 10;
    localparam int MAX_RETRY   = 3;
`ifdef SCCB_SEQ_DELAY_EN
    localparam bit c_DLY_EN = 1'b1;
`else
    localparam bit c_DLY_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        bit         ack;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy;
    logic        init_done;
    logic        err;

    sccb_sequencer_if bus ();

    sccb_sequencer #(
        .ROM_DEPTH   (ROM_DEPTH),
        .CLKS_PER_MS (CLKS_PER_MS),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .bus       (bus),
        .busy      (busy),
        .init_done (init_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Config ROM with one cycle of read latency.
    logic [15:0] rom_mem [0:255];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_hs     = 0;
    bit   eng_en   = 1'b1;
    bit   ack_tbl [0:255][0:MAX_RETRY-1];
    bit   exp_err  = 1'b0;
    int   exp_end_addr;
    int   exp_cycles;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp);
        n_checks++;
        if ((act > exp + 1) || (act < exp - 1)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d +/-1", name, act, exp);
        end
    endtask

    // Reference model: which commands the init sequence must issue, in order,
    // and how many busy cycles a table with no bus traffic takes.
    function automatic void model_init();
        int i;
        bit ok;
        i          = 0;
        exp_err    = 1'b0;
        exp_cycles = 0;
        while (1) begin
            exp_cycles += 2;
            if ((i == ROM_DEPTH) || (rom_mem[i] == 16'hFFFF)) break;
            if (rom_mem[i][15:8] == 8'hFE) begin
                if (c_DLY_EN)
                    exp_cycles += (rom_mem[i][7:0] == 8'd0) ? 1 : int'(rom_mem[i][7:0]) * CLKS_PER_MS;
            end else begin
                ok = 1'b0;
                for (int a = 0; (a < MAX_RETRY) && !ok; a++) begin
                    exp_q.push_back('{rom_mem[i][15:8], rom_mem[i][7:0], ack_tbl[i][a]});
                    ok = ack_tbl[i][a];
                end
                if (!ok) exp_err = 1'b1;
            end
            i++;
        end
        exp_end_addr = i;
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom_mem[i] = {8'(i), 8'h5A};
    endtask

    task automatic set_acks(input bit v);
        for (int i = 0; i < 256; i++)
            for (int a = 0; a < MAX_RETRY; a++) ack_tbl[i][a] = v;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Waits for busy to fall while poking host_valid and start, which must
    // both be ignored while busy.
    task automatic wait_idle(input string tag, output int cyc, output int viol);
        bit done;
        done = 1'b0;
        cyc  = 0;
        viol = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            cyc++;
            if (bus.host_ready) viol++;
            bus.host_valid = 1'($urandom_range(0, 1));
            bus.host_reg   = 8'($urandom);
            bus.host_data  = 8'($urandom);
            start          = ($urandom_range(0, 7) == 0);
        end
        bus.host_valid = 1'b0;
        start          = 1'b0;
        chk({tag, " finished_in_time"}, done, 1);
    endtask

    task automatic finish_checks(input string tag);
        chk({tag, " issues_left"}, exp_q.size(), 0);
        exp_q.delete();
        chk({tag, " busy"}, busy, 0);
        chk({tag, " init_done"}, init_done, 1);
        chk({tag, " err"}, err, exp_err);
        chk({tag, " host_ready"}, bus.host_ready, 1);
    endtask

    task automatic run_init(input string tag, input bit check_cycles);
        int cyc, viol;
        model_init();
        pulse_start();
        wait_idle(tag, cyc, viol);
        finish_checks(tag);
        chk({tag, " rom_addr"}, rom_addr, exp_end_addr);
        chk({tag, " host_ready_during_init"}, viol, 0);
        if (check_cycles) chk_tol({tag, " busy_cycles"}, cyc, exp_cycles);
    endtask

    task automatic host_write(input string tag, input logic [7:0] r, input logic [7:0] d,
                              input bit [MAX_RETRY-1:0] acks);
        int cyc, viol;
        bit ok;
        ok = 1'b0;
        for (int a = 0; (a < MAX_RETRY) && !ok; a++) begin
            exp_q.push_back('{r, d, acks[a]});
            ok = acks[a];
        end
        if (!ok) exp_err = 1'b1;
        @(posedge clk); #1;
        bus.host_valid = 1'b1;
        bus.host_reg   = r;
        bus.host_data  = d;
        @(posedge clk); #1;
        bus.host_valid = 1'b0;
        wait_idle(tag, cyc, viol);
        finish_checks(tag);
    endtask

    // Write-engine model and scoreboard monitor.
    initial begin : engine
        bit   ack;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!eng_en) continue;
            bus.wr_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (bus.wr_valid && bus.wr_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_issue: got reg %02h data %02h expected no command",
                             bus.wr_reg, bus.wr_data);
                    ack = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_reg_data", {bus.wr_reg, bus.wr_data}, {e.r, e.d});
                    ack = e.ack;
                end
                @(posedge clk); #1;
                bus.wr_ready = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                bus.wr_done   = 1'b1;
                bus.wr_ack_ok = ack;
                @(posedge clk); #1;
                bus.wr_done   = 1'b0;
                bus.wr_ack_ok = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hs0, len;
        bus.host_valid = 1'b0;
        bus.host_reg   = '0;
        bus.host_data  = '0;
        bus.wr_ready   = 1'b0;
        bus.wr_done    = 1'b0;
        bus.wr_ack_ok  = 1'b0;
        rom_clear();
        set_acks(1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset init_done", init_done, 0);
        chk("reset err", err, 0);
        chk("reset wr_valid", bus.wr_valid, 0);
        chk("reset host_ready", bus.host_ready, 0);
        chk("reset rom_addr", rom_addr, 0);
        reset = 1'b1;

        // Two-entry table, all ACKed.
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1101; rom_mem[2] = 16'hFFFF;
        hs0 = n_hs;
        run_init("basic", 1'b0);
        chk("basic handshakes", n_hs - hs0, 2);

        // Host writes after init: ACKed, then all NACKed (sets err).
        hs0 = n_hs;
        host_write("host_ack", 8'h3A, 8'h04, 3'b001);
        chk("host_ack handshakes", n_hs - hs0, 1);
        host_write("host_retry", 8'h44, 8'h55, 3'b100);
        host_write("host_nack", 8'h10, 8'h20, 3'b000);

        // First two attempts NACKed, third ACKed.
        rom_clear();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFFF;
        set_acks(1'b1);
        ack_tbl[0][0] = 1'b0; ack_tbl[0][1] = 1'b0;
        hs0 = n_hs;
        run_init("retry", 1'b0);
        chk("retry handshakes", n_hs - hs0, 3);

        // Everything NACKed.
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1101; rom_mem[2] = 16'hFFFF;
        set_acks(1'b0);
        hs0 = n_hs;
        run_init("all_nack", 1'b0);
        chk("all_nack handshakes", n_hs - hs0, 6);

        // Delay entries.
        set_acks(1'b1);
        rom_clear();
        rom_mem[0] = 16'hFE02; rom_mem[1] = 16'hFFFF;
        hs0 = n_hs;
        run_init("delay2", 1'b1);
        chk("delay2 handshakes", n_hs - hs0, 0);
        rom_mem[0] = 16'hFE00;
        run_init("delay0", 1'b1);

        // Table without END_WORD: stops at ROM_DEPTH.
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = {8'(8'h20 + i), 8'(i * 3)};
        rom_mem[ROM_DEPTH] = 16'h0000;
        run_init("saturate", 1'b0);

        // start and host_valid together in READY: restart wins.
        rom_clear();
        rom_mem[0] = 16'h2233; rom_mem[1] = 16'hFFFF;
        model_init();
        @(posedge clk); #1;
        start = 1'b1; bus.host_valid = 1'b1; bus.host_reg = 8'h55; bus.host_data = 8'h66;
        @(posedge clk); #1;
        start = 1'b0; bus.host_valid = 1'b0;
        @(negedge clk);
        chk("restart host_ready", bus.host_ready, 0);
        chk("restart busy", busy, 1);
        chk("restart init_done", init_done, 0);
        begin
            int cyc, viol;
            wait_idle("restart", cyc, viol);
        end
        finish_checks("restart");

        // Randomized tables and ACK patterns.
        for (int rnd = 0; rnd < 12; rnd++) begin
            rom_clear();
            len = $urandom_range(0, ROM_DEPTH);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0)
                    rom_mem[i] = {8'hFE, 8'($urandom_range(0, 2))};
                else
                    rom_mem[i] = {8'($urandom_range(0, 8'hFD)), 8'($urandom)};
            end
            if (len < ROM_DEPTH) rom_mem[len] = 16'hFFFF;
            for (int i = 0; i < 256; i++)
                for (int a = 0; a < MAX_RETRY; a++) ack_tbl[i][a] = ($urandom_range(0, 2) != 0);
            run_init($sformatf("rand%0d", rnd), 1'b0);
        end

        // Reset while waiting for wr_done.
        rom_clear();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFFF;
        eng_en = 1'b0;
        @(posedge clk); #2;
        bus.wr_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.wr_valid) break;
        end
        chk("rst reached_issue", bus.wr_valid, 1);
        @(posedge clk); #1 bus.wr_ready = 1'b1;
        @(posedge clk); #1 bus.wr_ready = 1'b0;
        @(negedge clk);
        chk("rst in_wait busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("rst async wr_valid", bus.wr_valid, 0);
        @(posedge clk); #1;
        chk("rst outputs", {rom_addr, busy, init_done, err, bus.wr_valid, bus.host_ready,
                            bus.wr_reg, bus.wr_data}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        bus.wr_done = 1'b1; bus.wr_ack_ok = 1'b1;
        @(posedge clk); #1;
        bus.wr_done = 1'b0; bus.wr_ack_ok = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst late_done busy", busy, 0);
        chk("rst late_done wr_valid", bus.wr_valid, 0);
        chk("rst late_done rom_addr", rom_addr, 0);
        chk("rst late_done init_done", init_done, 0);

        // Recovery after reset.
        eng_en = 1'b1;
        set_acks(1'b1);
        run_init("recover", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sccb_sequencer.md
SCCB_SEQUENCER -- requirements
Module: sccb_sequencer

Interface
REQ-001 Parameters SHALL be one per line, as name, default, meaning:
  ROM_DEPTH, 72, config-table entries
  CLKS_PER_MS, 50000, clk cycles per millisecond
  MAX_RETRY, 3, NACKed attempts before an entry is abandoned
REQ-002 Ports SHALL be one per line, as name, direction, width, meaning:
  clk  in  1  single clock, all logic on rising edge
  reset  in  1  asynchronous, active-low
  start  in  1  pulse, begins the init sequence
  rom_addr  out  8  config ROM address
  rom_data  in  16  {reg_addr, reg_data}; 1-cycle synchronous read latency
  host_valid  in  1  runtime write request
  host_ready  out  1  request accepted when high with host_valid
  host_reg  in  8  runtime register address
  host_data  in  8  runtime register data
  wr_valid  out  1  command to SCCB write engine
  wr_ready  in  1  engine accepts command
  wr_reg  out  8  register address to engine
  wr_data  out  8  register data to engine
  wr_done  in  1  one-cycle pulse, transaction finished
  wr_ack_ok  in  1  slave ACKed all bytes; qualified by wr_done
  busy  out  1  high in any state except IDLE and READY
  init_done  out  1  sticky; table completed
  err  out  1  sticky; some entry exhausted MAX_RETRY

Function
REQ-003 FSM states SHALL be IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, READY, H_ISSUE, H_WAIT.
REQ-004 IDLE: start -> FETCH; clear rom_addr, retry count, init_done and err.
REQ-005 FETCH: drive rom_addr for exactly one cycle -> DECODE, which samples rom_data.
REQ-006 DECODE: rom_data == 16'hFFFF, or rom_addr == ROM_DEPTH -> set init_done, go to READY.
REQ-006a DECODE: reg_addr == 8'hFE -> DELAY. All other entries -> ISSUE.
REQ-007 ISSUE/H_ISSUE: hold wr_valid with stable wr_reg/wr_data until wr_valid && wr_ready, then go to WAIT/H_WAIT.
REQ-008 WAIT: wr_done && wr_ack_ok -> increment rom_addr, clear retry count, go to FETCH.
REQ-009 WAIT: wr_done && !wr_ack_ok -> increment retry count.
REQ-009a On a NACK below MAX_RETRY, the same command SHALL be reissued.
REQ-009b On the MAX_RETRY-th NACK, err SHALL be set, the entry skipped, and the sequence continued.
REQ-010 DELAY: wait reg_data * CLKS_PER_MS cycles, then increment rom_addr and go to FETCH. reg_data == 0 SHALL delay exactly 1 cycle.
REQ-011 READY: host_ready = 1.
REQ-011a READY: accepted host request -> latch host_reg/host_data, go to H_ISSUE.
REQ-011b READY: start -> restart init, taking priority over a simultaneous host_valid.
REQ-012 H_WAIT SHALL follow the retry rules of REQ-008 to REQ-009b and return to READY; no ROM increment.
REQ-013 host_ready SHALL be 0 in every state except READY; host requests are never accepted during init.
REQ-014 start SHALL be ignored in every state except IDLE and READY.
REQ-015 rom_addr SHALL saturate at ROM_DEPTH; no wrap-around.
REQ-016 The retry counter SHALL be sized $clog2(MAX_RETRY+1) bits.
REQ-016a The delay counter SHALL be sized to hold 255*CLKS_PER_MS without overflow.

Reset
REQ-017 reset low SHALL asynchronously force IDLE and zero all outputs, counters and latched command registers.
REQ-018 Reset mid-transaction SHALL drop wr_valid immediately. A later wr_done SHALL be ignored outside WAIT/H_WAIT.

Configuration
REQ-019 With SCCB_SEQ_DELAY_EN defined, 8'hFE entries SHALL behave per REQ-010.
REQ-019a Without SCCB_SEQ_DELAY_EN, 8'hFE entries SHALL be skipped in one cycle (DECODE -> FETCH, rom_addr+1). No bus transaction and no delay logic.

Structure
REQ-020 Package sccb_pkg SHALL hold the state enum, END_WORD = 16'hFFFF and DELAY_REG = 8'hFE.
REQ-021 The millisecond prescaler and down-counter SHALL be sub-module sccb_delay_timer (load, ms count, expired pulse), instantiated only under SCCB_SEQ_DELAY_EN.

Verification
REQ-022 ROM {0x1280, 0x1101, 0xFFFF}, all ACK -> exactly two wr_valid handshakes (0x12/0x80, 0x11/0x01), then init_done = 1, err = 0, busy = 0.
REQ-023 Entry 0x1280 with first two attempts NACKed, MAX_RETRY = 3 -> three issues of 0x12/0x80, err = 0, rom_addr advances.
REQ-024 Every attempt NACKed -> 3 issues per entry, err = 1, init_done still = 1.
REQ-025 ROM {0xFE02, 0xFFFF}, CLKS_PER_MS = 10, macro on -> 20 (+/-1) cycles in DELAY. Macro off -> no wr_valid, immediate init_done.
REQ-026 host_valid during init -> host_ready = 0. After init, host 0x3A/0x04 issued once.
REQ-026a host_valid and start together in READY -> init restarts, host stays unaccepted.
REQ-027 reset low during WAIT -> all outputs 0 next cycle. A later wr_done pulse leaves state IDLE.
